// File: rtl/pwm_fir_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_fir_pkg                                                                |
// | Shared types, default low-pass table and arithmetic helpers for the FIR.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pwm_fir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_ROUND = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    localparam int c_def_taps = 24;

    // Symmetric Q1.15 low-pass, DC gain 24256/32768.
    localparam int c_def_coef [c_def_taps] = '{
          -32,   -64,   -48,    64,   288,   560,   768,   960,
         1344,  2048,  2848,  3392,  3392,  2848,  2048,  1344,
          960,   768,   560,   288,    64,   -48,   -64,   -32
    };

    localparam logic [1:0] c_sat_none = 2'd0;
    localparam logic [1:0] c_sat_hi   = 2'd1;
    localparam logic [1:0] c_sat_lo   = 2'd2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        return r;
    endfunction

    function automatic int default_coef(input int k);
        return c_def_coef[k % c_def_taps];
    endfunction

    // Classifies v against the signed range of a w-bit word.
    function automatic logic [1:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)      return c_sat_hi;
        else if (v < lo) return c_sat_lo;
        else             return c_sat_none;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_fir_mac_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_fir_mac_if                                                             |
// | Sample-in / sample-out strobe bus and status flags of the PWM FIR filter.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface pwm_fir_mac_if #(
    parameter int DATA_W = 16
) ();
    logic                     enable;
    logic signed [DATA_W-1:0] data_in;
    logic                     data_in_rdy;
    logic signed [DATA_W-1:0] data_out;
    logic                     data_out_rdy;
    logic                     busy;
    logic                     overrun;
    logic                     sat;

    modport master (
        output enable, data_in, data_in_rdy,
        input  data_out, data_out_rdy, busy, overrun, sat
    );

    modport slave (
        input  enable, data_in, data_in_rdy,
        output data_out, data_out_rdy, busy, overrun, sat
    );
endinterface
`default_nettype wire

// File: rtl/pwm_fir_hist_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_fir_hist_ram                                                           |
// | TAPS x DATA_W sample history, one write port, combinational read port.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pwm_fir_hist_ram
    import pwm_fir_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int TAPS   = 24
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       we,
    input  wire logic [clog2(TAPS)-1:0]     waddr,
    input  wire logic signed [DATA_W-1:0]   wdata,
    input  wire logic [clog2(TAPS)-1:0]     raddr,
    output logic signed [DATA_W-1:0]        rdata
);
    logic signed [DATA_W-1:0] r_mem [TAPS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) r_mem[i] <= '0;
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];
endmodule
`default_nettype wire

// File: rtl/pwm_fir_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_fir_mac                                                                |
// | Time-multiplexed FIR low-pass: one shared MAC iterates over TAPS taps.     |
// | Optional macro PWM_FIR_COEF_LOAD_EN adds a writable coefficient file.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pwm_fir_mac
    import pwm_fir_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int TAPS      = 24,
    parameter int ACC_W     = 40,
    parameter int OUT_SHIFT = 15
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    pwm_fir_mac_if.slave                  bus
`ifdef PWM_FIR_COEF_LOAD_EN
   ,input  wire logic                     coef_wr,
    input  wire logic [clog2(TAPS)-1:0]   coef_addr,
    input  wire logic signed [COEF_W-1:0] coef_data
`endif
);
    localparam int AW = clog2(TAPS);
    localparam int PW = DATA_W + COEF_W;
    localparam logic [AW-1:0] c_last = AW'(TAPS - 1);
    localparam logic [AW:0]   c_taps = (AW + 1)'(TAPS);
    localparam logic signed [ACC_W-1:0] c_half = {{(ACC_W-1){1'b0}}, 1'b1} << (OUT_SHIFT - 1);

    state_t r_state, w_state_nxt;

    logic [AW-1:0]             r_wr_ptr, r_rd_ptr, r_idx;
    logic signed [PW-1:0]      r_prod;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [DATA_W-1:0]  r_rounded;

    logic                      w_trigger, w_busy, w_load, w_mac, w_acc_en;
    logic                      w_round_en, w_out_en, w_ovr_set;
    logic signed [DATA_W-1:0]  w_hist;
    logic signed [COEF_W-1:0]  w_coef;
    logic signed [PW-1:0]      w_hist_ext, w_coef_ext;
    logic signed [ACC_W-1:0]   w_prod_ext, w_round_sum, w_shifted;
    logic [1:0]                w_sat_code;
    logic signed [DATA_W-1:0]  w_sat_val;

    assign w_trigger = bus.data_in_rdy & bus.enable;

    pwm_fir_hist_ram #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS)
    ) u_hist (
        .clk    (clk),
        .rst    (rst),
        .we     (w_load),
        .waddr  (r_wr_ptr),
        .wdata  (bus.data_in),
        .raddr  (r_rd_ptr),
        .rdata  (w_hist)
    );

`ifdef PWM_FIR_COEF_LOAD_EN
    logic signed [COEF_W-1:0] r_coef [TAPS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) r_coef[i] <= COEF_W'(default_coef(i));
        end else if (coef_wr && !w_busy && ({1'b0, coef_addr} < c_taps)) begin
            r_coef[coef_addr] <= coef_data;
        end
    end

    assign w_coef = r_coef[r_idx];
`else
    assign w_coef = COEF_W'(default_coef(int'(r_idx)));
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_trigger) w_state_nxt = ST_MAC;
            ST_MAC:   if (r_idx == c_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: w_state_nxt = ST_ROUND;
            ST_ROUND: w_state_nxt = ST_OUT;
            ST_OUT:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy     = (r_state != ST_IDLE);
        w_load     = (r_state == ST_IDLE) && w_trigger;
        w_mac      = (r_state == ST_MAC);
        w_acc_en   = ((r_state == ST_MAC) && (r_idx != '0)) || (r_state == ST_DRAIN);
        w_round_en = (r_state == ST_ROUND);
        w_out_en   = (r_state == ST_OUT);
        w_ovr_set  = w_trigger && (r_state != ST_IDLE);
    end

    assign bus.busy = w_busy;

    // Operands widened to the full product width so the multiply is signed end to end.
    assign w_hist_ext  = {{COEF_W{w_hist[DATA_W-1]}}, w_hist};
    assign w_coef_ext  = {{DATA_W{w_coef[COEF_W-1]}}, w_coef};
    assign w_prod_ext  = {{(ACC_W-PW){r_prod[PW-1]}}, r_prod};
    assign w_round_sum = r_acc + c_half;
    assign w_shifted   = w_round_sum >>> OUT_SHIFT;

    always_comb begin
        w_sat_code = saturate(64'(w_shifted), DATA_W);
        case (w_sat_code)
            c_sat_hi: w_sat_val = {1'b0, {(DATA_W-1){1'b1}}};
            c_sat_lo: w_sat_val = {1'b1, {(DATA_W-1){1'b0}}};
            default:  w_sat_val = w_shifted[DATA_W-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_idx            <= '0;
            r_prod           <= '0;
            r_acc            <= '0;
            r_rounded        <= '0;
            bus.data_out     <= '0;
            bus.data_out_rdy <= 1'b0;
            bus.overrun      <= 1'b0;
            bus.sat          <= 1'b0;
        end else begin
            bus.data_out_rdy <= w_out_en;
            if (w_load) begin
                r_rd_ptr <= r_wr_ptr;
                r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
                r_idx    <= '0;
                r_acc    <= '0;
            end
            // Newest sample pairs with coef[0]; read pointer walks backwards in time.
            if (w_mac) begin
                r_prod   <= w_hist_ext * w_coef_ext;
                r_rd_ptr <= (r_rd_ptr == '0) ? c_last : r_rd_ptr - 1'b1;
                r_idx    <= r_idx + 1'b1;
            end
            if (w_acc_en) r_acc <= r_acc + w_prod_ext;
            if (w_round_en) begin
                r_rounded <= w_sat_val;
                if (w_sat_code != c_sat_none) bus.sat <= 1'b1;
            end
            if (w_out_en)  bus.data_out <= r_rounded;
            if (w_ovr_set) bus.overrun  <= 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pwm_fir_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pwm_fir_mac                                                             |
// | Directed + random bench for pwm_fir_mac against a convolution model.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pwm_fir_mac;
    localparam int TAPS = 24;
    localparam int LAT  = TAPS + 3;

    logic clk;
    logic rst;
    pwm_fir_mac_if #(.DATA_W(16)) bus ();
`ifdef PWM_FIR_COEF_LOAD_EN
    logic              coef_wr;
    logic [4:0]        coef_addr;
    logic signed [15:0] coef_data;
`endif

    pwm_fir_mac #(
        .DATA_W    (16),
        .COEF_W    (16),
        .TAPS      (TAPS),
        .ACC_W     (40),
        .OUT_SHIFT (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef PWM_FIR_COEF_LOAD_EN
       ,.coef_wr   (coef_wr),
        .coef_addr (coef_addr),
        .coef_data (coef_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint hist_q[$];
    longint coef_m [TAPS] = '{
          -32,   -64,   -48,    64,   288,   560,   768,   960,
         1344,  2048,  2848,  3392,  3392,  2848,  2048,  1344,
          960,   768,   560,   288,    64,   -48,   -64,   -32
    };
    longint last_y = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        hist_q.delete();
        for (int i = 0; i < TAPS; i++) hist_q.push_back(0);
    endtask

    // y[n] = sat(round(sum c[k]*x[n-k] / 2^15))
    function automatic longint model_push(input longint x);
        longint acc;
        longint r;
        hist_q.push_front(x);
        void'(hist_q.pop_back());
        acc = 0;
        for (int k = 0; k < TAPS; k++) acc += hist_q[k] * coef_m[k];
        r = (acc + 16384) >>> 15;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    // Called at a negedge; returns at the negedge on which data_out_rdy is seen.
    task automatic run_sample(input logic signed [15:0] x, input string tag);
        int lat;
        bit seen;
        bus.data_in     = x;
        bus.data_in_rdy = 1'b1;
        @(negedge clk);
        bus.data_in_rdy = 1'b0;
        last_y = model_push(longint'(x));
        chk({tag, " busy"}, bus.busy, 1);
        lat  = 0;
        seen = 0;
        while (!seen && lat < 60) begin
            if (bus.data_out_rdy) seen = 1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk({tag, " latency"}, seen ? lat : -1, LAT);
        chk({tag, " data"}, bus.data_out, last_y);
    endtask

    task automatic impulse_train(input logic signed [15:0] amp, input string tag);
        for (int k = 0; k < TAPS; k++) begin
            run_sample((k == 0) ? amp : 16'sd0, tag);
            chk({tag, " tap"}, bus.data_out, (amp < 0) ? -coef_m[k] : coef_m[k]);
            @(negedge clk);
            chk({tag, " pulse"}, bus.data_out_rdy, 0);
            repeat (40 - LAT - 2) @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_cnt;
        int busy_cnt;
        logic signed [15:0] x;

        rst             = 1'b1;
        bus.enable      = 1'b1;
        bus.data_in     = '0;
        bus.data_in_rdy = 1'b0;
`ifdef PWM_FIR_COEF_LOAD_EN
        coef_wr   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
`endif
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset data_out", bus.data_out, 0);
        chk("reset data_out_rdy", bus.data_out_rdy, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset overrun", bus.overrun, 0);
        chk("reset sat", bus.sat, 0);

        impulse_train(16'sh7FFF, "pos_impulse");
        impulse_train(-16'sd32768, "neg_impulse");

        for (int n = 0; n < 20; n++) begin
            x = 16'($urandom);
            run_sample(x, "random");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Second strobe while the first is in flight.
        x = 16'sd12345;
        bus.data_in     = x;
        bus.data_in_rdy = 1'b1;
        @(negedge clk);
        bus.data_in_rdy = 1'b0;
        last_y = model_push(longint'(x));
        repeat (4) @(negedge clk);
        bus.data_in     = -16'sd20000;
        bus.data_in_rdy = 1'b1;
        @(negedge clk);
        bus.data_in_rdy = 1'b0;
        rdy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.data_out_rdy) begin
                rdy_cnt++;
                chk("overrun data", bus.data_out, last_y);
            end
            @(negedge clk);
        end
        chk("overrun rdy count", rdy_cnt, 1);
        chk("overrun flag", bus.overrun, 1);

        // Reset sampled on the 10th MAC edge.
        bus.data_in     = 16'sh4000;
        bus.data_in_rdy = 1'b1;
        @(negedge clk);
        bus.data_in_rdy = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre-reset busy", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("post-reset busy", bus.busy, 0);
        rdy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.data_out_rdy) rdy_cnt++;
            @(negedge clk);
        end
        chk("aborted rdy count", rdy_cnt, 0);
        chk("post-reset overrun", bus.overrun, 0);
        chk("post-reset data_out", bus.data_out, 0);
        model_clear();
        last_y = 0;
        impulse_train(16'sh7FFF, "clean_impulse");

        // Strobes with enable low must leave everything untouched.
        bus.enable = 1'b0;
        rdy_cnt  = 0;
        busy_cnt = 0;
        for (int n = 0; n < 5; n++) begin
            bus.data_in     = 16'($urandom);
            bus.data_in_rdy = 1'b1;
            @(negedge clk);
            bus.data_in_rdy = 1'b0;
            for (int i = 0; i < 30; i++) begin
                if (bus.busy) busy_cnt++;
                if (bus.data_out_rdy) rdy_cnt++;
                @(negedge clk);
            end
        end
        chk("gated busy", busy_cnt, 0);
        chk("gated rdy", rdy_cnt, 0);
        chk("gated overrun", bus.overrun, 0);
        chk("gated hold", bus.data_out, last_y);
        bus.enable = 1'b1;

        for (int n = 0; n < 4; n++) begin
            x = 16'($urandom);
            run_sample(x, "post_gate");
            repeat (2) @(negedge clk);
        end

`ifdef PWM_FIR_COEF_LOAD_EN
        for (int i = 0; i < TAPS; i++) begin
            coef_wr   = 1'b1;
            coef_addr = 5'(i);
            coef_data = 16'sh4000;
            coef_m[i] = 16384;
            @(negedge clk);
        end
        coef_wr = 1'b0;
        for (int n = 0; n < TAPS; n++) run_sample(16'sh7FFF, "dc_pos");
        chk("dc_pos final", bus.data_out, 32767);
        chk("sat flag", bus.sat, 1);
        for (int n = 0; n < TAPS; n++) run_sample(-16'sd32768, "dc_neg");
        chk("dc_neg final", bus.data_out, -32768);
`else
        chk("sat default table", bus.sat, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
